mem_arbiter: RTL and testbench

Round-robin arbiter sharing the single data-memory port (address, write data, write enable, read data) between up to N requesters, such as multiple `thread` instances or a core plus a loader. It serialises accesses one at a time, sequences the memory's read latency, and returns read data with a one-cycle acknowledge. It sits between the requesters and the memory, in the position the memory-select path of a core drives today.

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between the requesters/memory and the round-robin memory arbiter.
// The slave modport is the arbiter; the master modport is the environment.
interface mem_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int WORD_W  = 32
);
  logic [N_PORTS-1:0]             req;
  logic [N_PORTS-1:0]             req_we;
  logic [N_PORTS-1:0][WORD_W-1:0] req_addr;
  logic [N_PORTS-1:0][WORD_W-1:0] req_din;
  logic [N_PORTS-1:0]             ack;
  logic [WORD_W-1:0]              rsp_dout;
  logic                           busy;
  logic [WORD_W-1:0]              mem_addr;
  logic [WORD_W-1:0]              mem_din;
  logic                           mem_write_en;
  logic [WORD_W-1:0]              mem_dout;

  modport master (
    output req, req_we, req_addr, req_din, mem_dout,
    input  ack, rsp_dout, busy, mem_addr, mem_din, mem_write_en
  );

  modport slave (
    input  req, req_we, req_addr, req_din, mem_dout,
    output ack, rsp_dout, busy, mem_addr, mem_din, mem_write_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising N requesters onto one data-memory port,
// sequencing the memory read latency and returning a one-cycle ack.
//
// state  | meaning
// IDLE   | search upward from r_ptr for a request, latch the winner
// ACCESS | drive latched address/data, write strobe for writes
// WAIT   | count down the memory read latency, capture at count 1
// RESP   | pulse ack for the winner, advance r_ptr past it
module mem_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int WORD_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_win;
  logic               w_found;
  logic               r_we;
  logic [WORD_W-1:0]  r_addr;
  logic [WORD_W-1:0]  r_din;
  logic [WORD_W-1:0]  r_rsp;
  logic [2:0]         r_cnt;
  logic [N_PORTS-1:0] r_ack;
  logic               w_capture;
  logic               w_load_cnt;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!w_found && bus.req[(int'(r_ptr) + i) % N_PORTS]) begin
        w_found = 1'b1;
        w_win   = IDX_W'((int'(r_ptr) + i) % N_PORTS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_load_cnt = 1'b0;
    case (r_state)
      IDLE: if (w_found) w_next = ACCESS;
      ACCESS: begin
        if (r_we) begin
          w_next = RESP;
        end else if (READ_LATENCY == 0) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end else begin
          w_load_cnt = 1'b1;
          w_next     = WAIT;
        end
      end
      WAIT: begin
        // <= rather than == so a corrupted count can never wedge the FSM
        if (r_cnt <= 3'd1) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_idx  <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
      r_rsp  <= '0;
      r_cnt  <= '0;
      r_ack  <= '0;
    end else begin
      r_ack <= '0;
      if (r_state == IDLE && w_found) begin
        r_idx  <= w_win;
        r_we   <= bus.req_we[w_win];
        r_addr <= bus.req_addr[w_win];
        r_din  <= bus.req_din[w_win];
      end
      if (w_load_cnt)             r_cnt <= 3'(READ_LATENCY);
      else if (r_state == WAIT)   r_cnt <= r_cnt - 3'd1;
      if (w_capture)              r_rsp <= bus.mem_dout;
      if (w_next == RESP)         r_ack[r_idx] <= 1'b1;
      if (r_state == RESP)
        r_ptr <= (r_idx == IDX_W'(N_PORTS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // Strobe decoded from state so reset drops it without waiting for a clock
  assign bus.mem_write_en = (r_state == ACCESS) && r_we;
  assign bus.ack          = r_ack;
  assign bus.rsp_dout     = r_rsp;
  assign bus.busy         = (r_state != IDLE);
  assign bus.mem_addr     = r_addr;
  assign bus.mem_din      = r_din;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance with read latency 1 and one
// with combinational read, each against a simple address-hash memory model.
module tb_mem_arbiter;
  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  logic [31:0] model_rsp1;
  logic [31:0] model_rsp0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hDEAD_BEFF;
  endfunction

  mem_arbiter_if #(.N_PORTS(4), .WORD_W(32)) bus1 ();
  mem_arbiter_if #(.N_PORTS(4), .WORD_W(32)) bus0 ();

  mem_arbiter #(.N_PORTS(4), .WORD_W(32), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mem_arbiter #(.N_PORTS(4), .WORD_W(32), .READ_LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  always @(posedge clk) bus1.mem_dout <= mem_f(bus1.mem_addr);
  assign bus0.mem_dout = mem_f(bus0.mem_addr);

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus1.ack !== 4'b0) $display("FAIL rst_ack got %b exp 0", bus1.ack); else n_pass++;
    n_checks++; if (bus1.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus1.busy); else n_pass++;
    n_checks++; if (bus1.mem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", bus1.mem_addr); else n_pass++;
    n_checks++; if (bus1.mem_din !== 32'h0) $display("FAIL rst_din got %h exp 0", bus1.mem_din); else n_pass++;
    n_checks++; if (bus1.mem_write_en !== 1'b0) $display("FAIL rst_we got %b exp 0", bus1.mem_write_en); else n_pass++;
    n_checks++; if (bus1.rsp_dout !== 32'h0) $display("FAIL rst_rsp got %h exp 0", bus1.rsp_dout); else n_pass++;
    n_checks++; if (bus0.busy !== 1'b0) $display("FAIL rst_busy0 got %b exp 0", bus0.busy); else n_pass++;
    rst = 1'b0;
    model_rsp1 = 32'h0;
    model_rsp0 = 32'h0;
  endtask

  task automatic test_single_read();
    exp_t e;
    logic [3:0] exp_ack;
    bit done = 0;
    bit we_seen = 0;
    sb.delete();
    @(negedge clk);
    bus1.req_we[2] = 1'b0;
    bus1.req_addr[2] = 32'h0000_0010;
    bus1.req[2] = 1'b1;
    sb.push_back('{port: 2, data: 32'hDEAD_BEEF});
    for (int k = 1; k <= 12 && !done; k++) begin
      @(negedge clk);
      if (bus1.mem_write_en) we_seen = 1;
      if (bus1.ack != 4'b0) begin
        done = 1;
        bus1.req[2] = 1'b0;
        e = sb.pop_front();
        exp_ack = '0; exp_ack[e.port] = 1'b1;
        model_rsp1 = e.data;
        n_checks++; if (k != 3) $display("FAIL read_lat got %0d exp 3", k); else n_pass++;
        n_checks++; if (bus1.ack !== exp_ack) $display("FAIL read_ack got %b exp %b", bus1.ack, exp_ack); else n_pass++;
        n_checks++; if (bus1.rsp_dout !== e.data) $display("FAIL read_rsp got %h exp %h", bus1.rsp_dout, e.data); else n_pass++;
      end
    end
    n_checks++; if (!done) $display("FAIL read_timeout got no ack exp ack"); else n_pass++;
    n_checks++; if (we_seen) $display("FAIL read_we got 1 exp 0"); else n_pass++;
  endtask

  task automatic test_single_write();
    exp_t e;
    bit done = 0;
    bit we_bad = 0;
    sb.delete();
    @(negedge clk);
    bus1.req_we[0] = 1'b1;
    bus1.req_addr[0] = 32'h20;
    bus1.req_din[0] = 32'h1234_5678;
    bus1.req[0] = 1'b1;
    sb.push_back('{port: 0, data: model_rsp1});
    for (int k = 1; k <= 12 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (bus1.mem_write_en !== 1'b1) $display("FAIL wr_we got %b exp 1", bus1.mem_write_en); else n_pass++;
        n_checks++; if (bus1.mem_addr !== 32'h20) $display("FAIL wr_addr got %h exp 20", bus1.mem_addr); else n_pass++;
        n_checks++; if (bus1.mem_din !== 32'h1234_5678) $display("FAIL wr_din got %h exp 12345678", bus1.mem_din); else n_pass++;
        n_checks++; if (bus1.busy !== 1'b1) $display("FAIL wr_busy got %b exp 1", bus1.busy); else n_pass++;
      end else if (bus1.mem_write_en !== 1'b0) begin
        we_bad = 1;
      end
      if (bus1.ack != 4'b0) begin
        done = 1;
        bus1.req[0] = 1'b0;
        bus1.req_we[0] = 1'b0;
        e = sb.pop_front();
        n_checks++; if (k != 2) $display("FAIL wr_lat got %0d exp 2", k); else n_pass++;
        n_checks++; if (bus1.ack !== 4'b0001) $display("FAIL wr_ack got %b exp 0001", bus1.ack); else n_pass++;
        n_checks++; if (bus1.rsp_dout !== e.data) $display("FAIL wr_rsp got %h exp %h", bus1.rsp_dout, e.data); else n_pass++;
      end
    end
    n_checks++; if (!done) $display("FAIL wr_timeout got no ack exp ack"); else n_pass++;
    n_checks++; if (we_bad) $display("FAIL wr_we_extra got 1 exp 0"); else n_pass++;
  endtask

  task automatic test_ptr_wrap();
    exp_t e;
    logic [3:0] exp_ack;
    int n = 0;
    sb.delete();
    // Serve port 2 so the pointer lands on 3
    @(negedge clk);
    bus1.req_addr[2] = 32'h30;
    bus1.req[2] = 1'b1;
    sb.push_back('{port: 2, data: mem_f(32'h30)});
    @(negedge clk);
    bus1.req_addr[0] = 32'h100;
    bus1.req_addr[3] = 32'h300;
    sb.push_back('{port: 3, data: mem_f(32'h300)});
    sb.push_back('{port: 0, data: mem_f(32'h100)});
    for (int k = 1; k <= 40 && n < 3; k++) begin
      @(negedge clk);
      if (bus1.ack != 4'b0 && sb.size() > 0) begin
        e = sb.pop_front();
        exp_ack = '0; exp_ack[e.port] = 1'b1;
        model_rsp1 = e.data;
        n_checks++; if (bus1.ack !== exp_ack) $display("FAIL wrap_ack%0d got %b exp %b", n, bus1.ack, exp_ack); else n_pass++;
        n_checks++; if (bus1.rsp_dout !== e.data) $display("FAIL wrap_rsp%0d got %h exp %h", n, bus1.rsp_dout, e.data); else n_pass++;
        bus1.req[bus1.ack == 4'b0100 ? 2 : (bus1.ack == 4'b1000 ? 3 : 0)] = 1'b0;
        if (n == 0) begin
          bus1.req[0] = 1'b1;
          bus1.req[3] = 1'b1;
        end
        n++;
      end
    end
    n_checks++; if (n != 3) $display("FAIL wrap_count got %0d exp 3", n); else n_pass++;
    bus1.req = '0;
  endtask

  task automatic test_fairness();
    exp_t e;
    logic [3:0] exp_ack;
    int n = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < 4; p++) begin
      bus1.req_we[p] = 1'b0;
      bus1.req_addr[p] = 32'h400 + 32'(p * 4);
    end
    bus1.req = 4'b1111;
    for (int r = 0; r < 8; r++) sb.push_back('{port: r % 4, data: mem_f(32'h400 + 32'((r % 4) * 4))});
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 60 && n < 8; k++) begin
      @(negedge clk);
      if (bus1.ack != 4'b0 && sb.size() > 0) begin
        e = sb.pop_front();
        exp_ack = '0; exp_ack[e.port] = 1'b1;
        model_rsp1 = e.data;
        n_checks++; if (bus1.ack !== exp_ack) $display("FAIL fair_ack%0d got %b exp %b", n, bus1.ack, exp_ack); else n_pass++;
        n_checks++; if (k != 3 + 4 * n) $display("FAIL fair_time%0d got %0d exp %0d", n, k, 3 + 4 * n); else n_pass++;
        n_checks++; if (bus1.rsp_dout !== e.data) $display("FAIL fair_rsp%0d got %h exp %h", n, bus1.rsp_dout, e.data); else n_pass++;
        n++;
        if (n == 8) bus1.req = '0;
      end
    end
    n_checks++; if (n != 8) $display("FAIL fair_count got %0d exp 8", n); else n_pass++;
    bus1.req = '0;
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    logic [3:0] exp_ack;
    int n = 0;
    bit ack_seen = 0;
    sb.delete();
    // Port 1 first so the pointer moves off zero before the abort
    @(negedge clk);
    bus1.req_addr[1] = 32'h11;
    bus1.req[1] = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus1.ack !== 4'b0010) $display("FAIL mid_pre_ack got %b exp 0010", bus1.ack); else n_pass++;
    bus1.req[1] = 1'b0;
    @(negedge clk);
    bus1.req_addr[2] = 32'h22;
    bus1.req[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus1.busy !== 1'b1) $display("FAIL mid_busy got %b exp 1", bus1.busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus1.busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", bus1.busy); else n_pass++;
    n_checks++; if (bus1.mem_addr !== 32'h0) $display("FAIL mid_rst_addr got %h exp 0", bus1.mem_addr); else n_pass++;
    n_checks++; if (bus1.mem_write_en !== 1'b0) $display("FAIL mid_rst_we got %b exp 0", bus1.mem_write_en); else n_pass++;
    n_checks++; if (bus1.rsp_dout !== 32'h0) $display("FAIL mid_rst_rsp got %h exp 0", bus1.rsp_dout); else n_pass++;
    model_rsp1 = 32'h0;
    bus1.req[2] = 1'b0;
    bus1.req_addr[1] = 32'h1A;
    bus1.req_addr[3] = 32'h3A;
    bus1.req[1] = 1'b1;
    bus1.req[3] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus1.ack !== 4'b0) ack_seen = 1;
    end
    n_checks++; if (ack_seen) $display("FAIL mid_rst_noack got ack exp none"); else n_pass++;
    sb.push_back('{port: 1, data: mem_f(32'h1A)});
    sb.push_back('{port: 3, data: mem_f(32'h3A)});
    rst = 1'b0;
    for (int k = 1; k <= 30 && n < 2; k++) begin
      @(negedge clk);
      if (bus1.ack != 4'b0 && sb.size() > 0) begin
        e = sb.pop_front();
        exp_ack = '0; exp_ack[e.port] = 1'b1;
        n_checks++; if (bus1.ack !== exp_ack) $display("FAIL mid_after_ack%0d got %b exp %b", n, bus1.ack, exp_ack); else n_pass++;
        n_checks++; if (bus1.rsp_dout !== e.data) $display("FAIL mid_after_rsp%0d got %h exp %h", n, bus1.rsp_dout, e.data); else n_pass++;
        if (n == 0) begin
          n_checks++; if (k != 3) $display("FAIL mid_after_lat got %0d exp 3", k); else n_pass++;
        end
        bus1.req[e.port] = 1'b0;
        n++;
      end
    end
    n_checks++; if (n != 2) $display("FAIL mid_after_count got %0d exp 2", n); else n_pass++;
    bus1.req = '0;
  endtask

  task automatic test_latency0();
    exp_t e;
    logic [3:0] exp_ack;
    logic [31:0] addr_tab [2] = '{32'h44, 32'h48};
    logic        we_tab   [2] = '{1'b0, 1'b1};
    int          port_tab [2] = '{1, 2};
    for (int t = 0; t < 2; t++) begin
      bit done = 0;
      bit we_bad = 0;
      sb.delete();
      @(negedge clk);
      bus0.req_we[port_tab[t]] = we_tab[t];
      bus0.req_addr[port_tab[t]] = addr_tab[t];
      bus0.req_din[port_tab[t]] = 32'hCAFE_0000 + 32'(t);
      bus0.req[port_tab[t]] = 1'b1;
      if (!we_tab[t]) model_rsp0 = mem_f(addr_tab[t]);
      sb.push_back('{port: port_tab[t], data: model_rsp0});
      for (int k = 1; k <= 10 && !done; k++) begin
        @(negedge clk);
        if (bus0.mem_write_en !== ((k == 1) ? we_tab[t] : 1'b0)) we_bad = 1;
        if (bus0.ack != 4'b0) begin
          done = 1;
          bus0.req[port_tab[t]] = 1'b0;
          e = sb.pop_front();
          exp_ack = '0; exp_ack[e.port] = 1'b1;
          n_checks++; if (k != 2) $display("FAIL l0_lat%0d got %0d exp 2", t, k); else n_pass++;
          n_checks++; if (bus0.ack !== exp_ack) $display("FAIL l0_ack%0d got %b exp %b", t, bus0.ack, exp_ack); else n_pass++;
          n_checks++; if (bus0.rsp_dout !== e.data) $display("FAIL l0_rsp%0d got %h exp %h", t, bus0.rsp_dout, e.data); else n_pass++;
        end
      end
      n_checks++; if (!done) $display("FAIL l0_timeout%0d got no ack exp ack", t); else n_pass++;
      n_checks++; if (we_bad) $display("FAIL l0_we%0d got wrong strobe exp ACCESS-only", t); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus1.req = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_din = '0;
    bus0.req = '0; bus0.req_we = '0; bus0.req_addr = '0; bus0.req_din = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_ptr_wrap();
    test_fairness();
    test_reset_mid_wait();
    test_latency0();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
